// File: rtl/console_sample.sv
// -----------------------------------------------------------------------------
// console_sample
//   Responder end of the console sample-tick handshake. Each rising edge of the
//   fs strobe is acknowledged with a one-cycle fd pulse so the tick generator
//   can re-arm. When idle, that edge also starts a frame. A frame scans NUM_CH
//   channels over a req/ack ADC interface and streams one word per channel on
//   a valid/ready port. The last word of the frame is flagged with dout_last.
//
//   Optional feature macro: CONSOLE_SAMPLE_HEADER_EN
//     When defined, every frame starts with a header word that carries a frame
//     counter: {8'hA5, frame_cnt[DW-9:0]}. A frame is then NUM_CH+1 words.
//     When undefined, there is no header state and no frame counter, and a
//     frame is NUM_CH words.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   work_i         enable; low forces a synchronous abort to idle
//   fs_i           sample strobe (level, may stay high for many cycles)
//   fd_o           fs acknowledge, one-cycle pulse
//   adc_req_o      conversion request, held until adc_ack_i
//   adc_ch_o       channel index, stable while adc_req_o is high
//   adc_ack_i      conversion done, adc_data_i valid in this cycle
//   adc_data_i     conversion result
//   dout_o         stream word
//   dout_valid_o   stream valid, held until dout_ready_i
//   dout_last_o    last word of the frame, qualified by dout_valid_o
//   dout_ready_i   stream backpressure
//   busy_o         frame in progress
//   overrun_o      sticky: an fs edge arrived while busy
//   err_timeout_o  sticky: an ADC conversion timed out
// -----------------------------------------------------------------------------
module console_sample #(
  parameter int NUM_CH  = 8,
  parameter int DW      = 16,
  parameter int CH_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            work_i,
  input  logic            fs_i,
  output logic            fd_o,
  output logic            adc_req_o,
  output logic [CH_W-1:0] adc_ch_o,
  input  logic            adc_ack_i,
  input  logic [DW-1:0]   adc_data_i,
  output logic [DW-1:0]   dout_o,
  output logic            dout_valid_o,
  output logic            dout_last_o,
  input  logic            dout_ready_i,
  output logic            busy_o,
  output logic            overrun_o,
  output logic            err_timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_HEAD,
    S_REQ,
    S_PUSH,
    S_DONE
  } state_e;

  localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);

  state_e          state_q, state_d;
  logic            fs_d_q;
  logic            fd_q;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            ovr_q, ovr_d;
  logic            err_q, err_d;
  logic            fs_rise;
  logic            tmo_hit;
  logic            last_ch;

`ifdef CONSOLE_SAMPLE_HEADER_EN
  localparam int FC_W = DW - 8;
  logic [FC_W-1:0] frame_q, frame_d;
`endif

  // A level held high never re-triggers: only the 0->1 transition counts.
  assign fs_rise = fs_i & ~fs_d_q;
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign last_ch = (ch_q == CH_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!work_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (fs_rise) state_d = S_ACK;
`ifdef CONSOLE_SAMPLE_HEADER_EN
        S_ACK:  state_d = S_HEAD;
        S_HEAD: if (dout_ready_i) state_d = S_REQ;
`else
        S_ACK:  state_d = S_REQ;
`endif
        // An ack arriving on the timeout cycle still ends the request normally.
        S_REQ:  if (adc_ack_i || tmo_hit) state_d = S_PUSH;
        S_PUSH: if (dout_ready_i) state_d = last_ch ? S_DONE : S_REQ;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    adc_req_o     = (state_q == S_REQ);
    adc_ch_o      = ch_q;
    dout_o        = dout_q;
    dout_valid_o  = (state_q == S_PUSH) || (state_q == S_HEAD);
    dout_last_o   = (state_q == S_PUSH) && last_ch;
    busy_o        = (state_q != S_IDLE);
    fd_o          = fd_q;
    overrun_o     = ovr_q;
    err_timeout_o = err_q;
  end

  // Datapath next-state: channel index, timeout counter, output word, flags
  always_comb begin
    ch_d   = ch_q;
    tmo_d  = tmo_q;
    dout_d = dout_q;
    err_d  = err_q;
    // The DONE cycle still counts as busy, so an edge there is an overrun.
    ovr_d  = ovr_q | (fs_rise && (state_q != S_IDLE));
`ifdef CONSOLE_SAMPLE_HEADER_EN
    frame_d = frame_q;
`endif
    if (!work_i) begin
      ch_d  = '0;
      tmo_d = '0;
      ovr_d = 1'b0;
      err_d = 1'b0;
`ifdef CONSOLE_SAMPLE_HEADER_EN
      frame_d = '0;
`endif
    end else begin
      case (state_q)
        S_ACK: begin
          ch_d  = '0;
          tmo_d = '0;
`ifdef CONSOLE_SAMPLE_HEADER_EN
          dout_d = {8'hA5, frame_q};
`endif
        end
        S_REQ: begin
          if (adc_ack_i) begin
            dout_d = adc_data_i;
            tmo_d  = '0;
          end else if (tmo_hit) begin
            dout_d = '1;
            err_d  = 1'b1;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        S_PUSH: begin
          if (dout_ready_i && !last_ch) ch_d = ch_q + CH_W'(1);
        end
`ifdef CONSOLE_SAMPLE_HEADER_EN
        S_DONE: frame_d = frame_q + FC_W'(1);
`endif
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_d_q <= 1'b0;
      fd_q   <= 1'b0;
      ch_q   <= '0;
      tmo_q  <= '0;
      dout_q <= '0;
      ovr_q  <= 1'b0;
      err_q  <= 1'b0;
`ifdef CONSOLE_SAMPLE_HEADER_EN
      frame_q <= '0;
`endif
    end else begin
      fs_d_q <= fs_i;
      // Every edge is acknowledged, busy or not, so the tick always re-arms.
      fd_q   <= fs_rise & work_i;
      ch_q   <= ch_d;
      tmo_q  <= tmo_d;
      dout_q <= dout_d;
      ovr_q  <= ovr_d;
      err_q  <= err_d;
`ifdef CONSOLE_SAMPLE_HEADER_EN
      frame_q <= frame_d;
`endif
    end
  end

endmodule

// File: tb/tb_console_sample.sv
`timescale 1ns/1ps
module tb_console_sample;
  localparam int NUM_CH  = 8;
  localparam int DW      = 16;
  localparam int CH_W    = 4;
  localparam int TIMEOUT = 255;
`ifdef CONSOLE_SAMPLE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int FRAME_WORDS = NUM_CH + HDR;

  logic            clk, rst_n, work, fs, adc_ack, dout_ready;
  logic [DW-1:0]   adc_data;
  logic            fd, adc_req, dout_valid, dout_last, busy, overrun, err_timeout;
  logic [CH_W-1:0] adc_ch;
  logic [DW-1:0]   dout;

  console_sample #(.NUM_CH(NUM_CH), .DW(DW), .CH_W(CH_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .work_i(work), .fs_i(fs), .fd_o(fd),
    .adc_req_o(adc_req), .adc_ch_o(adc_ch), .adc_ack_i(adc_ack), .adc_data_i(adc_data),
    .dout_o(dout), .dout_valid_o(dout_valid), .dout_last_o(dout_last),
    .dout_ready_i(dout_ready), .busy_o(busy), .overrun_o(overrun),
    .err_timeout_o(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: expected stream words and frame bookkeeping
  logic [DW-1:0] exp_q[$];
  int words = 0, frame_no = 0, exp_ch = 0, frames_done = 0, fd_pulses = 0;
  logic fs_old = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, req_prev = 1'b0;
  logic [DW-1:0] prev_dout = '0, req_data = '0;
  int req_len = 0, req_delay = 0, fs_cnt = 0;

  // Scenario knobs
  int fixed_delay = -1, noack_ch = -1, late_ch = -1, stall_word = -1, stall_left = 0;
  int dbl_word = -1, abort_ch = -1;
  bit stall_used = 0, dbl_used = 0, fs_at_done = 0, rand_ready = 0, abort_pend = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One clock cycle: observe and check at the falling edge, then drive inputs.
  task automatic step();
    logic o_fd, o_req, o_valid, o_last;
    logic [CH_W-1:0] o_ch;
    logic [DW-1:0] o_dout, want;
    bit ab;
    @(negedge clk);
    o_fd = fd; o_req = adc_req; o_valid = dout_valid; o_last = dout_last;
    o_ch = adc_ch; o_dout = dout;
    ab = abort_pend;

    chk("fd", o_fd, fs & ~fs_old & work);
    if (o_fd) fd_pulses++;
    if (prev_valid && !prev_ready) begin
      chk("hold_valid", o_valid, 1);
      chk("hold_dout", o_dout, prev_dout);
    end
    if (o_valid) chk("no_req_in_push", o_req, 0);

    if (ab) begin
      chk("abort_req", o_req, 0);
      chk("abort_valid", o_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ch", o_ch, 0);
      chk("abort_ovr", overrun, 0);
      chk("abort_err", err_timeout, 0);
      exp_q.delete();
      words = 0; exp_ch = 0; frame_no = 0;
      abort_pend = 0;
      work = 1'b1;
    end

    if (o_req && !req_prev) begin
      chk("adc_ch", o_ch, exp_ch);
      if (exp_ch == noack_ch) req_delay = -1;
      else if (exp_ch == late_ch) req_delay = TIMEOUT - 1;
      else if (fixed_delay >= 0) req_delay = fixed_delay;
      else req_delay = int'($urandom_range(0, 5));
      req_data = DW'($urandom);
      exp_q.push_back((req_delay < 0) ? {DW{1'b1}} : req_data);
      req_len = 0;
    end
    if (o_req) req_len++;
    if (!o_req && req_prev && !ab) begin
      chk("req_len", req_len, (req_delay < 0) ? TIMEOUT : req_delay + 1);
      exp_ch++;
    end
    req_prev = o_req;

    // Drive inputs for the next rising edge
    if (dbl_word >= 0 && !dbl_used && words >= dbl_word && words < FRAME_WORDS - 1 &&
        fs == 1'b0 && fs_cnt == 0) begin
      fs_cnt = 4;
      dbl_used = 1;
    end
    fs_old = fs;
    fs = (fs_cnt > 0);
    if (fs_cnt > 0) fs_cnt--;

    if (abort_ch >= 0 && o_req && exp_ch == abort_ch) begin
      work = 1'b0;
      abort_pend = 1;
      abort_ch = -1;
    end

    adc_ack = o_req && !abort_pend && (req_delay >= 0) && (req_len - 1 == req_delay);
    adc_data = adc_ack ? req_data : DW'($urandom);

    if (stall_word >= 0 && !stall_used && o_valid && words == stall_word) begin
      stall_used = 1;
      stall_left = 20;
    end
    if (stall_left > 0) begin
      dout_ready = 1'b0;
      stall_left--;
    end else begin
      dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Handshake completes at the next rising edge
    if (o_valid && dout_ready) begin
      if (HDR != 0 && words == 0) begin
        want = {8'hA5, frame_no[DW-9:0]};
      end else if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
        want = '0;
      end else begin
        want = exp_q.pop_front();
      end
      chk("dout", o_dout, want);
      chk("dout_last", o_last, (words == FRAME_WORDS - 1));
      words++;
      if (words == FRAME_WORDS) begin
        words = 0; frames_done++; frame_no++; exp_ch = 0;
        if (fs_at_done) begin
          fs_at_done = 0;
          fs_cnt = 3;
        end
      end
    end
    prev_valid = o_valid;
    prev_ready = dout_ready;
    prev_dout  = o_dout;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic run_frames(input int n, input int budget);
    int target, c;
    target = frames_done + n;
    c = 0;
    while (frames_done < target && c < budget) begin
      step();
      c++;
    end
    chk("frame_budget", (frames_done >= target), 1);
  endtask

  initial begin
    int c, p0, f0;
    rst_n = 1'b0; work = 1'b1; fs = 1'b0; adc_ack = 1'b0; dout_ready = 1'b1; adc_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_fd", fd, 0);
    chk("rst_req", adc_req, 0);
    chk("rst_ch", adc_ch, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    idle(3);

    // Basic frame: fs held 10 cycles, ack 3 cycles after request
    fixed_delay = 3;
    p0 = fd_pulses;
    fs_cnt = 10;
    run_frames(1, 300);
    idle(5);
    chk("t1_fd_count", fd_pulses - p0, 1);
    chk("t1_ovr", overrun, 0);
    chk("t1_err", err_timeout, 0);
    chk("t1_busy", busy, 0);

    // Ack on the very cycle the timeout would fire: data wins, no error
    fixed_delay = -1;
    late_ch = 3;
    fs_cnt = 10;
    run_frames(1, 900);
    idle(3);
    late_ch = -1;
    chk("late_ack_err", err_timeout, 0);

    // fs edge in the DONE cycle: overrun, no new frame
    fs_at_done = 1;
    fs_cnt = 10;
    run_frames(1, 300);
    idle(10);
    chk("done_edge_ovr", overrun, 1);
    chk("done_edge_busy", busy, 0);

    // Channel 2 never acknowledged
    noack_ch = 2;
    fs_cnt = 10;
    run_frames(1, 900);
    idle(3);
    noack_ch = -1;
    chk("tmo_err", err_timeout, 1);
    chk("tmo_ovr_sticky", overrun, 1);

    // Backpressure: ready low 20 cycles on channel 4's word
    stall_word = HDR + 4;
    fs_cnt = 10;
    run_frames(1, 400);
    idle(3);
    chk("stall_used", stall_used, 1);
    chk("stall_err_sticky", err_timeout, 1);

    // work dropped during channel 5 request
    abort_ch = 5;
    fs_cnt = 10;
    c = 0;
    while ((abort_ch >= 0 || abort_pend) && c < 300) begin
      step();
      c++;
    end
    chk("abort_budget", (abort_ch < 0 && !abort_pend), 1);
    idle(3);
    fs_cnt = 10;
    run_frames(1, 300);
    idle(3);

    // Second fs edge mid-frame
    fixed_delay = 3;
    dbl_word = HDR + 3;
    p0 = fd_pulses;
    fs_cnt = 10;
    run_frames(1, 300);
    f0 = frames_done;
    idle(30);
    chk("dbl_fd_count", fd_pulses - p0, 2);
    chk("dbl_ovr", overrun, 1);
    chk("dbl_busy", busy, 0);
    chk("dbl_no_second_frame", frames_done, f0);

    // Random delays, random ready, several frames
    fixed_delay = -1;
    rand_ready = 1;
    for (int i = 0; i < 3; i++) begin
      fs_cnt = int'($urandom_range(1, 12));
      run_frames(1, 600);
      idle(int'($urandom_range(2, 6)));
    end
    chk("final_busy", busy, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
